// File: rtl/port_bufid_enqueue_responder_pkg.sv
// rtl/port_bufid_enqueue_responder_pkg.sv - shared widths, queue entry layout and FSM states
package port_bufid_enqueue_responder_pkg;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int BUFID_W = 9;
    localparam int TYPE_W  = 3;
    localparam int CNT_W   = 16;

    // Occupancy value at which the queue counts as full.
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

    // Queue entry: type in the upper bits, bufid in the lower bits.
    typedef struct packed {
        logic [TYPE_W-1:0]  pkt_type;
        logic [BUFID_W-1:0] bufid;
    } q_entry_t;

    typedef enum logic {
        IDLE_S,
        WAIT_LOW_S
    } state_t;

endpackage

// File: rtl/bufid_sync_fifo.sv
// rtl/bufid_sync_fifo.sv - show-ahead register FIFO of {type,bufid} entries
module bufid_sync_fifo
    import port_bufid_enqueue_responder_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              wr_en,
    input  q_entry_t          wr_data,
    input  logic              rd_en,
    output q_entry_t          rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   used
);

    q_entry_t          mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   used_q;
    logic              do_wr;
    logic              do_rd;

    // Writes into a full queue and reads from an empty one are ignored.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Entry storage; contents are meaningless until written so no reset.
    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push/pop balance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   used_q <= used_q + (ADDR_W + 1)'(1);
                2'b01:   used_q <= used_q - (ADDR_W + 1)'(1);
                default: used_q <= used_q;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (used_q == FULL_LVL);
    assign empty   = (used_q == '0);
    assign used    = used_q;

endmodule

// File: rtl/port_bufid_enqueue_responder.sv
// rtl/port_bufid_enqueue_responder.sv - per-port bufid req/ack responder with enqueue and drop reporting
module port_bufid_enqueue_responder
    import port_bufid_enqueue_responder_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [BUFID_W-1:0] iv_pkt_bufid,
    input  logic [TYPE_W-1:0]  iv_pkt_type,
    input  logic               i_pkt_bufid_req,
    output logic               o_pkt_bufid_ack,
    output logic [BUFID_W-1:0] ov_deq_pkt_bufid,
    output logic [TYPE_W-1:0]  ov_deq_pkt_type,
    output logic               o_deq_valid,
    input  logic               i_deq_rd,
    output logic [ADDR_W:0]    ov_queue_used,
    output logic               o_pkt_drop_valid,
    output logic [BUFID_W-1:0] ov_pkt_drop_bufid,
    output logic [CNT_W-1:0]   ov_drop_cnt
);

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              ack_q;
    logic              drop_q;
    q_entry_t          entry_q;
    logic [CNT_W-1:0]  drop_cnt_q;
    q_entry_t          head;
    logic              fifo_full;
    logic              fifo_empty;

    // State register for the request handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE_S;
        end else begin
            state_q <= state_d;
        end
    end

    // Accept a request only from IDLE_S, then wait for req to drop so it is never acked twice.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE_S: begin
                if (i_pkt_bufid_req) begin
                    accept  = 1'b1;
                    state_d = WAIT_LOW_S;
                end
            end
            WAIT_LOW_S: begin
                if (!i_pkt_bufid_req) begin
                    state_d = IDLE_S;
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    // Capture the request and decide drop vs enqueue from the occupancy seen at the accepting edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack_q   <= 1'b0;
            drop_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            ack_q  <= accept;
            drop_q <= accept && fifo_full;
            if (accept) begin
                entry_q <= '{pkt_type: iv_pkt_type, bufid: iv_pkt_bufid};
            end
        end
    end

    // Saturating drop counter, updated together with the drop pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_cnt_q <= '0;
        end else if (accept && fifo_full && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    // The write lands at the end of the ack cycle, so a reset during the ack abandons it.
    bufid_sync_fifo u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .wr_en   (ack_q && !drop_q),
        .wr_data (entry_q),
        .rd_en   (i_deq_rd),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .used    (ov_queue_used)
    );

    assign o_pkt_bufid_ack   = ack_q;
    assign o_pkt_drop_valid  = drop_q;
    assign ov_pkt_drop_bufid = drop_q ? entry_q.bufid : '0;
    assign ov_drop_cnt       = drop_cnt_q;
    assign o_deq_valid       = !fifo_empty;
    // Head is forced to zero when empty so stale storage never shows on the outputs.
    assign ov_deq_pkt_bufid  = fifo_empty ? '0 : head.bufid;
    assign ov_deq_pkt_type   = fifo_empty ? '0 : head.pkt_type;

endmodule

// File: tb/tb_port_bufid_enqueue_responder.sv
// tb/tb_port_bufid_enqueue_responder.sv - self-checking bench with a queue-based reference model
module tb_port_bufid_enqueue_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  bufid_in;
    logic [2:0]  type_in;
    logic        req;
    logic        ack;
    logic [8:0]  deq_bufid;
    logic [2:0]  deq_type;
    logic        deq_valid;
    logic        deq_rd;
    logic [4:0]  used;
    logic        drop_valid;
    logic [8:0]  drop_bufid;
    logic [15:0] drop_cnt;

    int          tests = 0;
    int          fails = 0;

    logic [11:0] mq[$];
    logic [15:0] m_drops;

    always #5 clk = ~clk;

    port_bufid_enqueue_responder dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .iv_pkt_bufid      (bufid_in),
        .iv_pkt_type       (type_in),
        .i_pkt_bufid_req   (req),
        .o_pkt_bufid_ack   (ack),
        .ov_deq_pkt_bufid  (deq_bufid),
        .ov_deq_pkt_type   (deq_type),
        .o_deq_valid       (deq_valid),
        .i_deq_rd          (deq_rd),
        .ov_queue_used     (used),
        .o_pkt_drop_valid  (drop_valid),
        .ov_pkt_drop_bufid (drop_bufid),
        .ov_drop_cnt       (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag);
        logic [11:0] e;
        e = (mq.size() > 0) ? mq[0] : 12'h000;
        chk({tag, "_valid"}, 32'(deq_valid), 32'(mq.size() > 0));
        chk({tag, "_bufid"}, 32'(deq_bufid), 32'(e[8:0]));
        chk({tag, "_type"},  32'(deq_type),  32'(e[11:9]));
        chk({tag, "_used"},  32'(used),      32'(mq.size()));
    endtask

    // One full handshake; hold = extra cycles req stays high beyond the registered clear.
    task automatic send_req(input logic [8:0] b, input logic [2:0] t, input int hold,
                            input bit pop_req, input bit pop_ack);
        bit was_full;
        chk("ack_idle", 32'(ack), 32'd0);
        check_head("pre");
        bufid_in = b;
        type_in  = t;
        req      = 1'b1;
        deq_rd   = pop_req;
        @(posedge clk); #1;
        was_full = (mq.size() == 16);
        if (pop_req && mq.size() > 0) void'(mq.pop_front());
        if (was_full && m_drops != 16'hffff) m_drops++;
        deq_rd = 1'b0;
        chk("ack_pulse",  32'(ack),        32'd1);
        chk("drop_valid", 32'(drop_valid), 32'(was_full));
        chk("drop_bufid", 32'(drop_bufid), was_full ? 32'(b) : 32'd0);
        chk("drop_cnt",   32'(drop_cnt),   32'(m_drops));
        check_head("ackcyc");
        deq_rd = pop_ack;
        @(posedge clk); #1;
        if (pop_ack && mq.size() > 0) void'(mq.pop_front());
        if (!was_full) mq.push_back({t, b});
        deq_rd = 1'b0;
        chk("ack_once",      32'(ack),        32'd0);
        chk("drop_off",      32'(drop_valid), 32'd0);
        chk("drop_bufid_off", 32'(drop_bufid), 32'd0);
        check_head("post");
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("ack_hold", 32'(ack), 32'd0);
        end
        req = 1'b0;
        @(posedge clk); #1;
        chk("ack_release", 32'(ack), 32'd0);
    endtask

    task automatic pop_one();
        check_head("pop_pre");
        deq_rd = 1'b1;
        @(posedge clk); #1;
        deq_rd = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        check_head("pop_post");
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; deq_rd = 1'b0; bufid_in = '0; type_in = '0;
        m_drops = '0;
        repeat (2) @(posedge clk);
        #1;
        check_head("reset");
        chk("reset_ack",  32'(ack),        32'd0);
        chk("reset_drop", 32'(drop_valid), 32'd0);
        chk("reset_cnt",  32'(drop_cnt),   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single request, then slow requester
        send_req(9'h005, 3'd3, 0, 1'b0, 1'b0);
        send_req(9'(($urandom_range(0, 511))), 3'($urandom_range(0, 7)), 3, 1'b0, 1'b0);
        while (mq.size() > 0) pop_one();
        pop_one();

        // Fill, overflow, then overflow with a simultaneous pop
        for (int i = 0; i < 16; i++)
            send_req(9'($urandom_range(0, 511)), 3'($urandom_range(0, 7)), 0, 1'b0, 1'b0);
        send_req(9'h1AB, 3'($urandom_range(0, 7)), 0, 1'b0, 1'b0);
        send_req(9'($urandom_range(0, 511)), 3'($urandom_range(0, 7)), 0, 1'b1, 1'b0);
        chk("full_pop_used", 32'(used), 32'd15);
        for (int i = 0; i < 15; i++) pop_one();

        // Mixed enqueue/dequeue traffic across pointer wrap
        for (int i = 0; i < 20; i++) begin
            send_req(9'($urandom_range(0, 511)), 3'($urandom_range(0, 7)),
                     int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) pop_one();
        end
        for (int i = 0; i < 20 && mq.size() > 0; i++) pop_one();
        chk("drain_used",  32'(used),      32'd0);
        chk("drain_valid", 32'(deq_valid), 32'd0);

        // Reset in the middle of a handshake with 4 entries queued
        for (int i = 0; i < 4; i++)
            send_req(9'($urandom_range(0, 511)), 3'($urandom_range(0, 7)), 0, 1'b0, 1'b0);
        bufid_in = 9'($urandom_range(0, 511));
        req = 1'b1;
        @(posedge clk); #1;
        chk("rst_pre_ack", 32'(ack), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        mq.delete();
        m_drops = '0;
        chk("rst_ack",   32'(ack),        32'd0);
        chk("rst_drop",  32'(drop_valid), 32'd0);
        chk("rst_dbuf",  32'(drop_bufid), 32'd0);
        chk("rst_cnt",   32'(drop_cnt),   32'd0);
        check_head("rst");
        req = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check_head("rst_after");
        send_req(9'h0C3, 3'd5, 0, 1'b0, 1'b0);
        pop_one();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
